// File: rtl/csr_pipe_pkg.sv
// Shared types and helpers for the EX->MEM->WB exception/CSR pipeline.
package csr_pipe_pkg;

  localparam int unsigned ECW = 7;

  typedef logic [ECW-1:0] ecode_t;

  localparam ecode_t INT_CODE = 7'h00;

  typedef struct packed {
    logic        valid;
    logic        excp;
    ecode_t      ecode;
    logic        badv_we;
    logic [31:0] badv;
    logic [31:0] pc;
  } lane_info_t;

  typedef enum logic {StIdle = 1'b0, StPend = 1'b1} pend_e;

  // Index of the lowest set bit (lane 0 is oldest); 0 when nothing is set.
  function automatic int unsigned oldest_lane(input logic [31:0] req);
    oldest_lane = 0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) oldest_lane = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/excp_lane_sel.sv
// Branch kill, oldest-excepting-lane select and interrupt attach for the MEM stage.
module excp_lane_sel #(
  parameter int unsigned NLANE = 2,
  parameter int unsigned CSR_LANE = 1,
  parameter csr_pipe_pkg::ecode_t INT_CODE = csr_pipe_pkg::INT_CODE,
  localparam int unsigned LW = (NLANE > 1) ? $clog2(NLANE) : 1
) (
  input  csr_pipe_pkg::lane_info_t lanes [NLANE],
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     br_valid,
  input  logic [LW-1:0]            br_lane,
  input  logic                     int_pend,
  output logic [NLANE-1:0]         mem_valid,
  output logic [NLANE-1:0]         commit,
  output logic                     int_take,
  output logic                     trap,
  output logic                     badv_we,
  output logic                     csr_commit,
  output csr_pipe_pkg::ecode_t     ecode,
  output logic [31:0]              badv,
  output logic [31:0]              era
);
  import csr_pipe_pkg::*;

  logic [31:0]   vld_vec;
  logic [31:0]   exc_vec;
  int unsigned   oldest_v;
  int unsigned   oldest_x;
  logic          excp_any;
  logic [LW-1:0] sel;

  always_comb begin
    mem_valid = '0;
    for (int unsigned j = 0; j < NLANE; j++) begin
      mem_valid[j] = lanes[j].valid & ~(br_valid & (j > 32'(br_lane))) & ~flush;
    end
  end

  always_comb begin
    vld_vec = '0;
    exc_vec = '0;
    commit  = '0;
    vld_vec[NLANE-1:0] = mem_valid;
    for (int unsigned j = 0; j < NLANE; j++) begin
      exc_vec[j] = mem_valid[j] & lanes[j].excp;
    end
    oldest_v = oldest_lane(vld_vec);
    oldest_x = oldest_lane(exc_vec);
    excp_any = |exc_vec;
    int_take = int_pend & (|mem_valid) & ~stall & ~flush;
    trap     = int_take | excp_any;
    // An interrupt outranks every exception and attaches to the oldest live lane.
    sel      = int_take ? LW'(oldest_v) : LW'(oldest_x);
    ecode    = int_take ? INT_CODE : lanes[sel].ecode;
    badv_we  = ~int_take & excp_any & lanes[sel].badv_we;
    badv     = lanes[sel].badv;
    era      = lanes[sel].pc;
    for (int unsigned j = 0; j < NLANE; j++) begin
      commit[j] = mem_valid[j] & ~int_take & ~(excp_any & (j >= oldest_x));
    end
    csr_commit = commit[CSR_LANE];
  end

endmodule

// File: rtl/csr_excp_pipe.sv
// EX->MEM->WB pipeline for exception, interrupt and CSR-write state; one WB event per cycle.
module csr_excp_pipe #(
  parameter int unsigned NLANE = 2,
  parameter int unsigned ECW = csr_pipe_pkg::ECW,
  parameter int unsigned CSR_LANE = 1,
  parameter logic [ECW-1:0] INT_CODE = csr_pipe_pkg::INT_CODE,
  localparam int unsigned LW = (NLANE > 1) ? $clog2(NLANE) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  br_valid,
  input  logic [LW-1:0]         br_lane,
  input  logic                  int_req,
  input  logic [NLANE-1:0]      ex_valid,
  input  logic [NLANE-1:0]      ex_excp,
  input  logic [NLANE*ECW-1:0]  ex_ecode,
  input  logic [NLANE-1:0]      ex_badv_we,
  input  logic [NLANE*32-1:0]   ex_badv,
  input  logic [NLANE*32-1:0]   ex_pc,
  input  logic [31:0]           ex_csr_wmask,
  input  logic [13:0]           ex_csr_waddr,
  input  logic [31:0]           ex_csr_wdata,
  input  logic                  ex_ertn,
  output logic [NLANE-1:0]      mem_valid,
  output logic [NLANE-1:0]      wb_valid,
  output logic                  wb_trap,
  output logic                  wb_int,
  output logic [ECW-1:0]        wb_ecode,
  output logic                  wb_badv_we,
  output logic [31:0]           wb_badv,
  output logic [31:0]           wb_era,
  output logic                  wb_ertn,
  output logic                  wb_flush,
  output logic [31:0]           wb_csr_wmask,
  output logic [13:0]           wb_csr_waddr,
  output logic [31:0]           wb_csr_wdata
);
  import csr_pipe_pkg::*;

  logic [NLANE-1:0] mem_vld_q, mem_excp_q, mem_badv_we_q;
  ecode_t           mem_ecode_q [NLANE];
  logic [31:0]      mem_badv_q  [NLANE];
  logic [31:0]      mem_pc_q    [NLANE];
  logic [31:0]      mem_wmask_q, mem_wdata_q;
  logic [13:0]      mem_waddr_q;
  logic             mem_ertn_q;

  lane_info_t       lanes [NLANE];
  logic [NLANE-1:0] commit;
  logic             int_take, trap, badv_we, csr_commit, ertn_commit, int_pend, wb_adv;
  ecode_t           ecode;
  logic [31:0]      badv, era;
  pend_e            pend_q, pend_d;

  assign wb_adv      = ~stall & ~wb_flush;
  assign ertn_commit = csr_commit & mem_ertn_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_vld_q     <= '0;
      mem_excp_q    <= '0;
      mem_badv_we_q <= '0;
      mem_ecode_q   <= '{default: '0};
      mem_badv_q    <= '{default: '0};
      mem_pc_q      <= '{default: '0};
      mem_wmask_q   <= '0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      mem_ertn_q    <= 1'b0;
    end else if (wb_flush) begin
      mem_vld_q <= '0;
    end else if (!stall) begin
      // A taken MEM branch discards the wrong-path lanes arriving from EX.
      mem_vld_q     <= br_valid ? '0 : ex_valid;
      mem_excp_q    <= ex_excp;
      mem_badv_we_q <= ex_badv_we;
      for (int unsigned j = 0; j < NLANE; j++) begin
        mem_ecode_q[j] <= ex_ecode[j*ECW +: ECW];
        mem_badv_q[j]  <= ex_badv[j*32 +: 32];
        mem_pc_q[j]    <= ex_pc[j*32 +: 32];
      end
      mem_wmask_q <= ex_csr_wmask;
      mem_waddr_q <= ex_csr_waddr;
      mem_wdata_q <= ex_csr_wdata;
      mem_ertn_q  <= ex_ertn & ~(|ex_excp);
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NLANE; j++) begin
      lanes[j].valid   = mem_vld_q[j];
      lanes[j].excp    = mem_excp_q[j];
      lanes[j].ecode   = mem_ecode_q[j];
      lanes[j].badv_we = mem_badv_we_q[j];
      lanes[j].badv    = mem_badv_q[j];
      lanes[j].pc      = mem_pc_q[j];
    end
  end

  excp_lane_sel #(
    .NLANE    (NLANE),
    .CSR_LANE (CSR_LANE),
    .INT_CODE (INT_CODE)
  ) u_sel (
    .lanes      (lanes),
    .flush      (wb_flush),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_lane    (br_lane),
    .int_pend   (int_pend),
    .mem_valid  (mem_valid),
    .commit     (commit),
    .int_take   (int_take),
    .trap       (trap),
    .badv_we    (badv_we),
    .csr_commit (csr_commit),
    .ecode      (ecode),
    .badv       (badv),
    .era        (era)
  );

  always_ff @(posedge clk) begin
    if (!rstn) pend_q <= StIdle;
    else       pend_q <= pend_d;
  end

  always_comb begin
    pend_d = pend_q;
    case (pend_q)
      // The flush of a taken interrupt must not re-arm the pending state.
      StIdle:  if (int_req && !int_take && !(wb_flush && wb_int)) pend_d = StPend;
      StPend:  if (int_take || !int_req) pend_d = StIdle;
      default: pend_d = StIdle;
    endcase
  end

  always_comb begin
    int_pend = int_req | (pend_q == StPend);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_valid     <= '0;
      wb_trap      <= 1'b0;
      wb_int       <= 1'b0;
      wb_ecode     <= '0;
      wb_badv_we   <= 1'b0;
      wb_badv      <= '0;
      wb_era       <= '0;
      wb_ertn      <= 1'b0;
      wb_flush     <= 1'b0;
      wb_csr_wmask <= '0;
      wb_csr_waddr <= '0;
      wb_csr_wdata <= '0;
    end else if (wb_adv) begin
      wb_valid     <= commit;
      wb_trap      <= trap;
      wb_int       <= int_take;
      wb_ecode     <= ecode;
      wb_badv_we   <= badv_we;
      wb_badv      <= badv;
      wb_era       <= era;
      wb_ertn      <= ertn_commit;
      wb_flush     <= trap | ertn_commit;
      wb_csr_wmask <= csr_commit ? mem_wmask_q : '0;
      wb_csr_waddr <= mem_waddr_q;
      wb_csr_wdata <= mem_wdata_q;
    end else begin
      wb_valid     <= '0;
      wb_trap      <= 1'b0;
      wb_int       <= 1'b0;
      wb_badv_we   <= 1'b0;
      wb_ertn      <= 1'b0;
      wb_flush     <= 1'b0;
      wb_csr_wmask <= '0;
    end
  end

endmodule

// File: tb/tb_csr_excp_pipe.sv
// Scoreboard bench for csr_excp_pipe: directed scenarios plus randomized traffic.
module tb_csr_excp_pipe;

  logic        clk = 1'b0;
  logic        rstn, stall, br_valid, int_req, ex_ertn;
  logic [0:0]  br_lane;
  logic [1:0]  ex_valid, ex_excp, ex_badv_we;
  logic [13:0] ex_ecode;
  logic [63:0] ex_badv, ex_pc;
  logic [31:0] ex_csr_wmask, ex_csr_wdata;
  logic [13:0] ex_csr_waddr;
  logic [1:0]  mem_valid, wb_valid;
  logic        wb_trap, wb_int, wb_badv_we, wb_ertn, wb_flush;
  logic [6:0]  wb_ecode;
  logic [31:0] wb_badv, wb_era, wb_csr_wmask, wb_csr_wdata;
  logic [13:0] wb_csr_waddr;

  always #5 clk = ~clk;

  csr_excp_pipe #(.NLANE(2), .ECW(7), .CSR_LANE(1), .INT_CODE(7'h00)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .br_valid(br_valid), .br_lane(br_lane),
    .int_req(int_req), .ex_valid(ex_valid), .ex_excp(ex_excp), .ex_ecode(ex_ecode),
    .ex_badv_we(ex_badv_we), .ex_badv(ex_badv), .ex_pc(ex_pc), .ex_csr_wmask(ex_csr_wmask),
    .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata), .ex_ertn(ex_ertn),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .wb_trap(wb_trap), .wb_int(wb_int),
    .wb_ecode(wb_ecode), .wb_badv_we(wb_badv_we), .wb_badv(wb_badv), .wb_era(wb_era),
    .wb_ertn(wb_ertn), .wb_flush(wb_flush), .wb_csr_wmask(wb_csr_wmask),
    .wb_csr_waddr(wb_csr_waddr), .wb_csr_wdata(wb_csr_wdata)
  );

  typedef struct {
    bit v; bit excp; bit [6:0] ecode; bit bwe; bit [31:0] badv; bit [31:0] pc;
  } mlane_t;

  typedef struct {
    int due; bit [1:0] valid; bit trap; bit intr; bit [6:0] ecode; bit bwe;
    bit [31:0] badv; bit [31:0] era; bit ertn; bit flush;
    bit [31:0] wmask; bit [13:0] waddr; bit [31:0] wdata;
  } ev_t;

  mlane_t m_lane [2];
  bit [31:0] m_wmask, m_wdata;
  bit [13:0] m_waddr;
  bit m_ertn, m_pend, m_flush, m_flush_int;
  ev_t exp_q [$];

  int n_tests = 0, n_fail = 0, cyc = 0, int_cnt = 0, flush_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the spec says leaves WB after the coming clock edge.
  task automatic model_step();
    bit [1:0] mv;
    bit take;
    int e, o;
    ev_t ev;
    if (!rstn) begin
      foreach (m_lane[j]) m_lane[j] = '{default: 0};
      m_wmask = 0; m_waddr = 0; m_wdata = 0; m_ertn = 0;
      m_pend = 0; m_flush = 0; m_flush_int = 0;
      return;
    end
    for (int j = 0; j < 2; j++) mv[j] = m_lane[j].v && !(br_valid && j > int'(br_lane)) && !m_flush;
    check("mem_valid", 64'(mem_valid), 64'(mv));
    take = (int_req || m_pend) && (mv != 0) && !stall && !m_flush;
    ev = '{default: 0};
    if (!stall && !m_flush) begin
      if (take) begin
        o = mv[0] ? 0 : 1;
        ev.trap = 1; ev.intr = 1; ev.ecode = 7'h00; ev.era = m_lane[o].pc;
      end else begin
        e = 2;
        for (int j = 1; j >= 0; j--) if (mv[j] && m_lane[j].excp) e = j;
        for (int j = 0; j < 2; j++) ev.valid[j] = mv[j] && j < e;
        if (e < 2) begin
          ev.trap = 1; ev.ecode = m_lane[e].ecode; ev.era = m_lane[e].pc;
          ev.bwe = m_lane[e].bwe; ev.badv = m_lane[e].badv;
        end
        if (mv[1] && e > 1) begin
          ev.wmask = m_wmask; ev.waddr = m_waddr; ev.wdata = m_wdata; ev.ertn = m_ertn;
        end
      end
      ev.flush = ev.trap || ev.ertn;
      ev.due = cyc + 1;
      if (ev.valid != 0 || ev.trap || ev.ertn || ev.wmask != 0) exp_q.push_back(ev);
    end
    if (m_pend) begin
      if (take || !int_req) m_pend = 0;
    end else if (int_req && !take && !(m_flush && m_flush_int)) begin
      m_pend = 1;
    end
    if (m_flush) begin
      foreach (m_lane[j]) m_lane[j].v = 0;
    end else if (!stall) begin
      for (int j = 0; j < 2; j++) begin
        m_lane[j] = '{v: ex_valid[j] && !br_valid, excp: ex_excp[j], ecode: ex_ecode[j*7 +: 7],
                      bwe: ex_badv_we[j], badv: ex_badv[j*32 +: 32], pc: ex_pc[j*32 +: 32]};
      end
      m_wmask = ex_csr_wmask; m_waddr = ex_csr_waddr; m_wdata = ex_csr_wdata;
      m_ertn = ex_ertn && ex_excp == 0;
    end
    m_flush = ev.flush;
    m_flush_int = ev.intr;
  endtask

  // Monitor: compares whatever WB presents against the queued expectation for this cycle.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit act;
    cyc++;
    if (wb_int === 1'b1) int_cnt++;
    if (wb_flush === 1'b1) flush_cnt++;
    act = (wb_valid != 0) || wb_trap || wb_int || wb_ertn || wb_flush || wb_badv_we ||
          (wb_csr_wmask != 0);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("wb_valid", 64'(wb_valid), 64'(e.valid));
      check("wb_trap", 64'(wb_trap), 64'(e.trap));
      check("wb_int", 64'(wb_int), 64'(e.intr));
      check("wb_ertn", 64'(wb_ertn), 64'(e.ertn));
      check("wb_flush", 64'(wb_flush), 64'(e.flush));
      check("wb_csr_wmask", 64'(wb_csr_wmask), 64'(e.wmask));
      if (e.trap) begin
        check("wb_ecode", 64'(wb_ecode), 64'(e.ecode));
        check("wb_era", 64'(wb_era), 64'(e.era));
        check("wb_badv_we", 64'(wb_badv_we), 64'(e.bwe));
        if (e.bwe) check("wb_badv", 64'(wb_badv), 64'(e.badv));
      end
      if (e.wmask != 0) begin
        check("wb_csr_waddr", 64'(wb_csr_waddr), 64'(e.waddr));
        check("wb_csr_wdata", 64'(wb_csr_wdata), 64'(e.wdata));
      end
    end else if (act) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_wb_event: got valid=%b trap=%b int=%b ertn=%b flush=%b wmask=%0h expected none (cycle %0d)",
               wb_valid, wb_trap, wb_int, wb_ertn, wb_flush, wb_csr_wmask, cyc);
    end
  end

  task automatic tick();
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_excp = 0; ex_ecode = 0; ex_badv_we = 0; ex_badv = 0; ex_pc = 0;
    ex_csr_wmask = 0; ex_csr_waddr = 0; ex_csr_wdata = 0; ex_ertn = 0;
  endtask

  task automatic set_lane(int j, bit excp, bit [6:0] ec, bit bwe, bit [31:0] badv, bit [31:0] pc);
    ex_valid[j] = 1; ex_excp[j] = excp; ex_ecode[j*7 +: 7] = ec; ex_badv_we[j] = bwe;
    ex_badv[j*32 +: 32] = badv; ex_pc[j*32 +: 32] = pc;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_wb_valid"}, 64'(wb_valid), 0);
    check({tag, "_wb_trap"}, 64'(wb_trap), 0);
    check({tag, "_wb_int"}, 64'(wb_int), 0);
    check({tag, "_wb_flush"}, 64'(wb_flush), 0);
    check({tag, "_wb_ertn"}, 64'(wb_ertn), 0);
    check({tag, "_wb_csr_wmask"}, 64'(wb_csr_wmask), 0);
    check({tag, "_wb_badv_we"}, 64'(wb_badv_we), 0);
    check({tag, "_mem_valid"}, 64'(mem_valid), 0);
  endtask

  task automatic run_drop_int(int n);
    for (int k = 0; k < n; k++) begin
      if (wb_int === 1'b1) int_req = 0;
      tick();
    end
  endtask

  initial begin
    int c0;
    rstn = 0; stall = 0; br_valid = 0; br_lane = 0; int_req = 0;
    clear_ex();
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_wb_era", 64'(wb_era), 0);
    check("reset_wb_ecode", 64'(wb_ecode), 0);
    rstn = 1;

    // 1: lane1 exception, lane0 clean
    set_lane(0, 0, 7'h00, 0, 0, 32'h1c00_0000);
    set_lane(1, 1, 7'h09, 1, 32'hdead_beef, 32'h1c00_0004);
    tick(); clear_ex(); repeat (3) tick();

    // 2: branch in lane0 kills the CSR write in lane1
    set_lane(0, 0, 0, 0, 0, 32'h1c00_0010);
    set_lane(1, 0, 0, 0, 0, 32'h1c00_0014);
    ex_csr_wmask = 32'hffff_ffff; ex_csr_waddr = 14'h006; ex_csr_wdata = 32'h1234_5678;
    tick(); clear_ex(); br_valid = 1; br_lane = 0; tick(); br_valid = 0; repeat (2) tick();

    // CSR write commits, then an ertn commits and flushes
    set_lane(0, 0, 0, 0, 0, 32'h1c00_0020);
    set_lane(1, 0, 0, 0, 0, 32'h1c00_0024);
    ex_csr_wmask = 32'h0000_00ff; ex_csr_waddr = 14'h011; ex_csr_wdata = 32'hcafe_f00d;
    tick(); clear_ex();
    set_lane(1, 0, 0, 0, 0, 32'h1c00_0030); ex_ertn = 1;
    tick(); clear_ex(); repeat (3) tick();

    // 3: interrupt waits for a valid MEM lane
    c0 = int_cnt;
    int_req = 1;
    repeat (3) tick();
    set_lane(0, 0, 0, 0, 0, 32'h1c00_0100);
    tick(); clear_ex(); run_drop_int(5);
    check("s3_int_pulses", 64'(int_cnt - c0), 1);

    // 4: exception flush first, interrupt raised during it stays pending
    c0 = int_cnt; int_req = 0;
    set_lane(0, 1, 7'h0b, 0, 0, 32'h1c00_0200);
    tick(); clear_ex(); tick();
    int_req = 1; tick(); tick();
    set_lane(0, 0, 0, 0, 0, 32'h1c00_0300);
    tick(); clear_ex(); run_drop_int(5);
    check("s4_int_pulses", 64'(int_cnt - c0), 1);

    // 5: stall holds the exception in MEM
    c0 = flush_cnt; int_req = 0;
    set_lane(0, 0, 0, 0, 0, 32'h1c00_0400);
    set_lane(1, 1, 7'h09, 0, 0, 32'h1c00_0404);
    tick(); clear_ex(); stall = 1; repeat (4) tick(); stall = 0; repeat (4) tick();
    check("s5_flush_pulses", 64'(flush_cnt - c0), 1);

    // 6: reset during PEND with a trap held in MEM
    int_req = 1;
    set_lane(1, 1, 7'h09, 0, 0, 32'h1c00_0504);
    tick(); clear_ex(); stall = 1; tick();
    rstn = 0; tick();
    check_idle("s6");
    rstn = 1; stall = 0; int_req = 0; tick();
    check("s6_no_flush", 64'(wb_flush), 0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      clear_ex();
      rstn = ($urandom_range(299) != 0);
      stall = ($urandom_range(3) == 0);
      br_valid = ($urandom_range(5) == 0);
      br_lane = 1'($urandom_range(1));
      if (wb_int === 1'b1) int_req = 0;
      else if ($urandom_range(24) == 0) int_req = ~int_req;
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(3) != 0)
          set_lane(j, $urandom_range(4) == 0, 7'($urandom), 1'($urandom), $urandom, $urandom);
      end
      if ($urandom_range(2) == 0) begin
        ex_csr_wmask = $urandom; ex_csr_waddr = 14'($urandom); ex_csr_wdata = $urandom;
      end
      ex_ertn = ($urandom_range(9) == 0);
      tick();
    end

    rstn = 1; stall = 0; br_valid = 0; int_req = 0; clear_ex();
    repeat (6) tick();
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
